// File: rtl/spu_result_pipe.sv
// spu_result_pipe
//   Result/writeback pipeline for the SPU execution pipes. Each issued
//   instruction carries its destination, write-enable, clamped latency and
//   result through DEPTH stages to the register-file writeback port. It
//   provides NUM_FWD forwarding query ports with stall indication, and a
//   branch flush that kills the youngest FLUSH_DEPTH stages.
//
//   Optional statistics counters are enabled by the macro RESULT_PIPE_STAT_EN.
//   Without the macro, stat_wb_cnt and stat_kill_cnt are tied to 0.
//
// Ports
//   clk, reset (async, active-low)
//   issue_valid/addr/reg_write/lat/data : new entry, enters stage 1
//   flush                                : kill entries landing in stages 1..FLUSH_DEPTH
//   fwd_addr/fwd_hit/fwd_data/fwd_stall  : per-port forwarding query
//   wb_valid/addr/data/reg_write         : stage DEPTH writeback
//   stat_wb_cnt, stat_kill_cnt           : optional counters
module spu_result_pipe #(
   parameter int DATA_W      = 128,
   parameter int ADDR_W      = 7,
   parameter int DEPTH       = 7,
   parameter int LAT_W       = 3,
   parameter int NUM_FWD     = 3,
   parameter int FLUSH_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      issue_valid,
   input  logic [ADDR_W-1:0]         issue_addr,
   input  logic                      issue_reg_write,
   input  logic [LAT_W-1:0]          issue_lat,
   input  logic [DATA_W-1:0]         issue_data,
   input  logic                      flush,
   input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
   output logic [NUM_FWD-1:0]        fwd_hit,
   output logic [NUM_FWD*DATA_W-1:0] fwd_data,
   output logic [NUM_FWD-1:0]        fwd_stall,
   output logic                      wb_valid,
   output logic [ADDR_W-1:0]         wb_addr,
   output logic [DATA_W-1:0]         wb_data,
   output logic                      wb_reg_write,
   output logic [31:0]               stat_wb_cnt,
   output logic [31:0]               stat_kill_cnt
);

   localparam int LAST = DEPTH - 1;

   // index i holds pipeline stage i+1
   logic [DEPTH-1:0]  st_v;
   logic [DEPTH-1:0]  st_rw;
   logic [DEPTH-1:0]  st_rdy;
   logic [ADDR_W-1:0] st_addr [DEPTH];
   logic [LAT_W-1:0]  st_lat  [DEPTH];
   logic [DATA_W-1:0] st_data [DEPTH];

   logic [LAT_W-1:0]  lat_eff;
   logic              fw_found;
   logic              fw_rdy;
   logic [DATA_W-1:0] fw_data;

   always_comb begin
      lat_eff = issue_lat;
      if (issue_lat == '0)
         lat_eff = LAT_W'(1);
      else if (32'(issue_lat) > 32'(DEPTH))
         lat_eff = LAT_W'(DEPTH);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_v  <= '0;
         st_rw <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            st_addr[i] <= '0;
            st_lat[i]  <= '0;
            st_data[i] <= '0;
         end
      end else begin
         // a flush also swallows the instruction issuing on this edge
         st_v[0]    <= issue_valid & ~flush;
         st_rw[0]   <= issue_reg_write;
         st_addr[0] <= issue_addr;
         st_lat[0]  <= lat_eff;
         st_data[0] <= issue_data;
         for (int i = 1; i < DEPTH; i++) begin
            st_v[i]    <= st_v[i-1] & ~(flush && (i < FLUSH_DEPTH));
            st_rw[i]   <= st_rw[i-1];
            st_addr[i] <= st_addr[i-1];
            st_lat[i]  <= st_lat[i-1];
            st_data[i] <= st_data[i-1];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         st_rdy[i] = 32'(st_lat[i]) <= 32'(i + 1);
   end

   // Scan oldest to youngest so the youngest match is the one left standing;
   // a younger not-ready match therefore masks any older ready one.
   always_comb begin
      fwd_hit   = '0;
      fwd_stall = '0;
      fwd_data  = '0;
      fw_found  = 1'b0;
      fw_rdy    = 1'b0;
      fw_data   = '0;
      for (int p = 0; p < NUM_FWD; p++) begin
         fw_found = 1'b0;
         fw_rdy   = 1'b0;
         fw_data  = '0;
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (st_v[i] && st_rw[i] && (st_addr[i] == fwd_addr[p*ADDR_W +: ADDR_W])) begin
               fw_found = 1'b1;
               fw_rdy   = st_rdy[i];
               fw_data  = st_data[i];
            end
         end
         fwd_hit[p]   = fw_found & fw_rdy;
         fwd_stall[p] = fw_found & ~fw_rdy;
         fwd_data[p*DATA_W +: DATA_W] = (fw_found && fw_rdy) ? fw_data : '0;
      end
   end

   assign wb_valid     = st_v[LAST];
   assign wb_addr      = st_v[LAST] ? st_addr[LAST] : '0;
   assign wb_data      = st_v[LAST] ? st_data[LAST] : '0;
   assign wb_reg_write = st_v[LAST] & st_rw[LAST];

`ifdef RESULT_PIPE_STAT_EN
   logic [31:0] wb_cnt;
   logic [31:0] kill_cnt;
   logic [31:0] kill_now;

   // valid entries that would land in stages 1..FLUSH_DEPTH on this edge
   always_comb begin
      kill_now = 32'(issue_valid);
      for (int i = 1; i < FLUSH_DEPTH; i++)
         kill_now = kill_now + 32'(st_v[i-1]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_cnt   <= '0;
         kill_cnt <= '0;
      end else begin
         if (wb_reg_write)
            wb_cnt <= wb_cnt + 32'd1;
         if (flush)
            kill_cnt <= kill_cnt + kill_now;
      end
   end

   assign stat_wb_cnt   = wb_cnt;
   assign stat_kill_cnt = kill_cnt;
`else
   assign stat_wb_cnt   = '0;
   assign stat_kill_cnt = '0;
`endif

endmodule

// File: tb/tb_spu_result_pipe.sv
module tb_spu_result_pipe;

   localparam int DATA_W = 128;
   localparam int ADDR_W = 7;
   localparam int DEPTH  = 7;
   localparam int LAT_W  = 3;
   localparam int NFWD   = 3;
   localparam int FD     = 2;
   localparam int H      = 2048;

   logic                    clk = 1'b0;
   logic                    reset = 1'b0;
   logic                    issue_valid = 1'b0;
   logic [ADDR_W-1:0]       issue_addr = '0;
   logic                    issue_reg_write = 1'b0;
   logic [LAT_W-1:0]        issue_lat = '0;
   logic [DATA_W-1:0]       issue_data = '0;
   logic                    flush = 1'b0;
   logic [NFWD*ADDR_W-1:0]  fwd_addr = '0;
   logic [NFWD-1:0]         fwd_hit;
   logic [NFWD*DATA_W-1:0]  fwd_data;
   logic [NFWD-1:0]         fwd_stall;
   logic                    wb_valid;
   logic [ADDR_W-1:0]       wb_addr;
   logic [DATA_W-1:0]       wb_data;
   logic                    wb_reg_write;
   logic [31:0]             stat_wb_cnt;
   logic [31:0]             stat_kill_cnt;

   int checks = 0;
   int errors = 0;

   spu_result_pipe #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT_W(LAT_W),
      .NUM_FWD(NFWD), .FLUSH_DEPTH(FD)
   ) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .issue_reg_write(issue_reg_write), .issue_lat(issue_lat),
      .issue_data(issue_data), .flush(flush),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
      .fwd_stall(fwd_stall),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .wb_reg_write(wb_reg_write),
      .stat_wb_cnt(stat_wb_cnt), .stat_kill_cnt(stat_kill_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: one record per clock edge, holding the instruction issued on it.
   // The entry in stage k after edge e is the one issued on edge e-k+1.
   bit              h_v    [H];
   bit              h_rw   [H];
   logic [ADDR_W-1:0] h_addr [H];
   int              h_l    [H];
   logic [DATA_W-1:0] h_data [H];
   int              ecnt = 0;
   int unsigned     m_wb = 0;
   int unsigned     m_kill = 0;

   function automatic bit ent_v(input int e);
      return (e >= 1 && e < H) ? h_v[e] : 1'b0;
   endfunction

   function automatic int clamp_lat(input int l);
      if (l < 1) return 1;
      if (l > DEPTH) return DEPTH;
      return l;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < H; i++) h_v[i] = 1'b0;
         m_wb   = 0;
         m_kill = 0;
      end else if (ecnt < H - 1) begin
         if (ent_v(ecnt - DEPTH + 1) && h_rw[ecnt - DEPTH + 1]) m_wb++;
         ecnt++;
         h_v[ecnt]    = issue_valid && !flush;
         h_rw[ecnt]   = issue_reg_write;
         h_addr[ecnt] = issue_addr;
         h_l[ecnt]    = clamp_lat(int'(issue_lat));
         h_data[ecnt] = issue_data;
         if (flush) begin
            if (issue_valid) m_kill++;
            for (int j = 1; j < FD; j++) begin
               if (ent_v(ecnt - j)) begin
                  h_v[ecnt - j] = 1'b0;
                  m_kill++;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      int e;
      bit found;
      bit rdy;
      logic [DATA_W-1:0] d;
      e = ecnt - DEPTH + 1;
      chk("wb_valid", DATA_W'(wb_valid), DATA_W'(ent_v(e)));
      chk("wb_addr", DATA_W'(wb_addr), ent_v(e) ? DATA_W'(h_addr[e]) : '0);
      chk("wb_data", wb_data, ent_v(e) ? h_data[e] : '0);
      chk("wb_reg_write", DATA_W'(wb_reg_write), DATA_W'(ent_v(e) && h_rw[e]));
      for (int p = 0; p < NFWD; p++) begin
         found = 1'b0;
         rdy   = 1'b0;
         d     = '0;
         for (int k = 1; k <= DEPTH; k++) begin
            e = ecnt - k + 1;
            if (!found && ent_v(e) && h_rw[e] && h_addr[e] == fwd_addr[p*ADDR_W +: ADDR_W]) begin
               found = 1'b1;
               rdy   = (k >= h_l[e]);
               d     = h_data[e];
            end
         end
         chk("fwd_hit", DATA_W'(fwd_hit[p]), DATA_W'(found && rdy));
         chk("fwd_stall", DATA_W'(fwd_stall[p]), DATA_W'(found && !rdy));
         chk("fwd_data", fwd_data[p*DATA_W +: DATA_W], (found && rdy) ? d : '0);
      end
`ifdef RESULT_PIPE_STAT_EN
      chk("stat_wb_cnt", DATA_W'(stat_wb_cnt), DATA_W'(m_wb));
      chk("stat_kill_cnt", DATA_W'(stat_kill_cnt), DATA_W'(m_kill));
`else
      chk("stat_wb_cnt", DATA_W'(stat_wb_cnt), '0);
      chk("stat_kill_cnt", DATA_W'(stat_kill_cnt), '0);
`endif
   end

   // advance one edge; return just after the following falling edge
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic set_issue(input logic v, input int a, input int l, input logic [DATA_W-1:0] d, input logic rw);
      issue_valid     = v;
      issue_addr      = ADDR_W'(a);
      issue_lat       = LAT_W'(l);
      issue_data      = d;
      issue_reg_write = rw;
   endtask

   task automatic issue(input int a, input int l, input logic [DATA_W-1:0] d, input logic rw);
      set_issue(1'b1, a, l, d, rw);
      cyc();
      issue_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   localparam logic [DATA_W-1:0] D1 = 128'h0001_0001_0001_0001_0001_0001_0001_0001;
   localparam logic [DATA_W-1:0] DA = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
   localparam logic [DATA_W-1:0] DB = 128'hBBBB_7777_8888_9999_CCCC_DDDD_EEEE_FFFF;

   initial begin
      bit seen [4];
      reset = 1'b0;
      idle(2);
      chk("rst_wb_valid", DATA_W'(wb_valid), '0);
      chk("rst_fwd", DATA_W'({fwd_hit, fwd_stall}), '0);
      #2 reset = 1'b1;
      idle(1);

      // single entry: latency, ready point and exact writeback cycle
      fwd_addr = '0;
      fwd_addr[0 +: ADDR_W] = 7'd3;
      issue(3, 4, D1, 1'b1);
      for (int k = 1; k <= DEPTH; k++) begin
         chk("t1_stall", DATA_W'(fwd_stall[0]), DATA_W'(k < 4));
         chk("t1_hit", DATA_W'(fwd_hit[0]), DATA_W'(k >= 4));
         chk("t1_wb_valid", DATA_W'(wb_valid), DATA_W'(k == DEPTH));
         if (k == DEPTH) begin
            chk("t1_wb_addr", DATA_W'(wb_addr), DATA_W'(3));
            chk("t1_wb_data", wb_data, D1);
         end
         cyc();
      end
      chk("t1_wb_after", DATA_W'(wb_valid), '0);

      // younger not-ready match masks an older ready one
      fwd_addr[0 +: ADDR_W] = 7'd5;
      issue(5, 1, DA, 1'b1);
      chk("t3_a_hit", fwd_data[0 +: DATA_W], DA);
      issue(5, 6, DB, 1'b1);
      for (int k = 1; k <= DEPTH; k++) begin
         chk("t3_stall", DATA_W'(fwd_stall[0]), DATA_W'(k < 6));
         chk("t3_data", fwd_data[0 +: DATA_W], (k >= 6) ? DB : '0);
         cyc();
      end
      idle(2);

      // flush on the fourth consecutive issue
      fwd_addr[ADDR_W +: ADDR_W]   = 7'd10;
      fwd_addr[2*ADDR_W +: ADDR_W] = 7'd12;
      issue(10, 1, 128'd10, 1'b1);
      issue(11, 1, 128'd11, 1'b1);
      issue(12, 1, 128'd12, 1'b1);
      set_issue(1'b1, 13, 1, 128'd13, 1'b1);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      issue_valid = 1'b0;
`ifdef RESULT_PIPE_STAT_EN
      chk("t4_kill_cnt", DATA_W'(stat_kill_cnt), DATA_W'(2));
`endif
      for (int i = 0; i < 4; i++) seen[i] = 1'b0;
      for (int c = 0; c < DEPTH + 2; c++) begin
         if (wb_valid && wb_addr >= 10 && wb_addr <= 13) seen[wb_addr - 10] = 1'b1;
         cyc();
      end
      chk("t4_seen", DATA_W'({seen[3], seen[2], seen[1], seen[0]}), DATA_W'(4'b0011));

      // latency clamps and a non-writing entry
      fwd_addr = '0;
      fwd_addr[0 +: ADDR_W]        = 7'd20;
      fwd_addr[ADDR_W +: ADDR_W]   = 7'd21;
      fwd_addr[2*ADDR_W +: ADDR_W] = 7'd22;
      issue(21, 7, 128'h21, 1'b1);
      issue(20, 0, 128'h20, 1'b1);
      chk("t5_lat0_hit", fwd_data[0 +: DATA_W], 128'h20);
      issue(22, 1, 128'h22, 1'b0);
      for (int k = 3; k <= DEPTH; k++) begin
         chk("t5_lat7_stall", DATA_W'(fwd_stall[1]), DATA_W'(k < DEPTH));
         chk("t5_rw0_fwd", DATA_W'({fwd_hit[2], fwd_stall[2]}), '0);
         cyc();
      end
      idle(1);
      chk("t5_rw0_wb", DATA_W'({wb_valid, wb_reg_write, wb_addr}), DATA_W'({1'b1, 1'b0, 7'd22}));
      idle(1);

      // duplicate and mixed traffic, checked by the model
      for (int c = 0; c < 60; c++) begin
         set_issue(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 7),
                   {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
         flush = ($urandom_range(0, 7) == 0);
         for (int p = 0; p < NFWD; p++) fwd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3));
         cyc();
      end
      flush = 1'b0;
      issue_valid = 1'b0;
      idle(DEPTH + 1);

      // reset with three entries in flight
      fwd_addr = '0;
      issue(30, 7, 128'h30, 1'b1);
      issue(31, 7, 128'h31, 1'b1);
      issue(32, 7, 128'h32, 1'b1);
      fwd_addr[0 +: ADDR_W] = 7'd32;
      #1;
      chk("t6_pre_stall", DATA_W'(fwd_stall[0]), DATA_W'(1));
      reset = 1'b0;
      #1;
      chk("t6_rst_now", DATA_W'({wb_valid, wb_reg_write, fwd_hit, fwd_stall}), '0);
      chk("t6_rst_data", fwd_data[0 +: DATA_W], '0);
      cyc();
      reset = 1'b1;
      for (int c = 0; c < DEPTH + 2; c++) begin
         chk("t6_no_wb", DATA_W'(wb_valid), '0);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spu_result_pipe.md
Name: spu_result_pipe

Overview:
- Parametrised result/writeback pipeline for the SPU odd (and even) pipes.
- Carries each issued instruction's destination, write-enable and result through DEPTH stages to the register-file writeback port.
- Models per-unit execution latency, supplies multi-port forwarding with stall indication, and supports branch flush of younger instructions.
- Successor to the fixed 7-stage, single-forward writeback path.

Parameters:
- DATA_W, 128, result width in bits
- ADDR_W, 7, register address width
- DEPTH, 7, number of stages from issue to writeback (>=2)
- LAT_W, 3, width of the latency field
- NUM_FWD, 3, number of independent forwarding query ports
- FLUSH_DEPTH, 2, number of youngest stages killed by flush (1..DEPTH-1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  new instruction enters stage 1 at next edge
- issue_addr  in  ADDR_W  destination register
- issue_reg_write  in  1  instruction writes the register file
- issue_lat  in  LAT_W  unit latency in cycles
- issue_data  in  DATA_W  result value, carried with the entry
- flush  in  1  branch taken: kill younger stages
- fwd_addr  in  NUM_FWD*ADDR_W  query addresses, port i at bits [i*ADDR_W +: ADDR_W]
- fwd_hit  out  NUM_FWD  ready match found
- fwd_data  out  NUM_FWD*DATA_W  forwarded value
- fwd_stall  out  NUM_FWD  youngest match not yet ready
- wb_valid  out  1  writeback entry valid
- wb_addr  out  ADDR_W  writeback register
- wb_data  out  DATA_W  writeback value
- wb_reg_write  out  1  wb_valid AND entry reg_write
- stat_wb_cnt  out  32  committed writebacks (optional feature)
- stat_kill_cnt  out  32  entries killed by flush (optional feature)

Behaviour:
- Reset (reset==0, async): all stage valid bits clear, all outputs 0. Release is taken at the next edge. Reset mid-flight discards all entries; no writeback occurs for them.
- Stage k (1..DEPTH) holds the entry issued k edges earlier. Every edge shifts all stages by one; there is no back-pressure and the pipe never stalls internally.
- Stage DEPTH drives wb_* combinationally from registers. Writeback latency is exactly DEPTH cycles after the issue edge.
- Effective latency L = issue_lat clamped to 1..DEPTH: 0 is treated as 1, values >DEPTH are treated as DEPTH. Clamped L is stored per entry.
- An entry in stage k is "ready" when k >= L.
- Forwarding, per port i, combinational:
  - Candidates are valid entries in stages 1..DEPTH with reg_write=1 and addr==fwd_addr[i].
  - The youngest candidate (lowest k) wins.
  - If it is ready: fwd_hit=1, fwd_data=its data, fwd_stall=0.
  - If it is not ready: fwd_hit=0, fwd_stall=1, fwd_data=0.
  - No candidate: all three are 0.
  - Older matches never override a younger not-ready match.
- Flush at an edge:
  - Entries that would land in stages 1..FLUSH_DEPTH after the shift are invalidated. This includes the issuing instruction (issue_valid is ignored).
  - Older entries continue normally.
  - Forwarding in the flush cycle still reflects the pre-edge contents.
- Entries with reg_write=0 traverse the pipe: wb_valid=1 and wb_reg_write=0 at stage DEPTH. They are never forwarded.
- Duplicate destinations in flight are legal. Each writes back in order, and forwarding returns the youngest.

Optional Feature:
- Macro RESULT_PIPE_STAT_EN.
- Defined:
  - stat_wb_cnt increments on every cycle with wb_reg_write=1.
  - stat_kill_cnt adds the number of valid entries invalidated by each flush edge.
  - Both are 32-bit, wrap at 2^32-1 to 0, and reset to 0.
- Undefined: no counter logic is built and both ports are tied to 0.

Test Plan:
- Reset then issue addr=3, lat=4, data=128'h0001...0001, reg_write=1 -> wb_valid=1, wb_addr=3, wb_data=that value exactly 7 cycles later; wb_valid=0 in all other cycles.
- Same issue, fwd_addr[0]=3 -> fwd_stall[0]=1 for stages 1-3, fwd_hit[0]=1 with data for stages 4-7.
- Issue addr=5 lat=1 data=A, next cycle addr=5 lat=6 data=B -> fwd port queries 5: stall=1 (B not ready) while B is in stages 1-5, despite A being ready; hit with B from stage 6.
- Issue 4 consecutive entries (addr 10-13), assert flush on the 4th issue edge with FLUSH_DEPTH=2 -> entries 10 and 11 write back, 12 and 13 never do; stat_kill_cnt=2 when RESULT_PIPE_STAT_EN is defined.
- issue_lat=0 and issue_lat=7 -> ready at stage 1 and at stage 7 respectively; reg_write=0 entry -> wb_valid=1, wb_reg_write=0, fwd_hit=0.
- Assert reset low with 3 entries in flight -> all outputs 0 immediately; after release, no writeback for those entries.
